// File: rtl/check_std_rv32i.sv
// Operand-check/issue stage for the rv32i pipeline: holds a decoded instruction one
// cycle, waits for register-file operand validity, then issues it with operands to exec.
module check_std_rv32i (
  input  logic        CLK,
  input  logic        RST,
  input  logic        FLUSH,
  input  logic        MEM_WAIT,
  input  logic        DECODE_VALID,
  input  logic [31:0] DECODE_PC,
  input  logic [6:0]  DECODE_OPCODE,
  input  logic [4:0]  DECODE_RD,
  input  logic [4:0]  DECODE_RS1,
  input  logic [4:0]  DECODE_RS2,
  input  logic [2:0]  DECODE_FUNCT3,
  input  logic [6:0]  DECODE_FUNCT7,
  input  logic [31:0] DECODE_IMM,
  input  logic        REG_A_RVALID,
  input  logic [31:0] REG_A_RDATA,
  input  logic        REG_B_RVALID,
  input  logic [31:0] REG_B_RDATA,
  output logic        STALL,
  output logic [4:0]  FWD_REG_ADDR,
  output logic        CHECK_VALID,
  output logic [31:0] CHECK_PC,
  output logic [6:0]  CHECK_OPCODE,
  output logic [4:0]  CHECK_RD,
  output logic [4:0]  CHECK_RS1,
  output logic [4:0]  CHECK_RS2,
  output logic [2:0]  CHECK_FUNCT3,
  output logic [6:0]  CHECK_FUNCT7,
  output logic [31:0] CHECK_IMM,
  output logic [31:0] CHECK_RS1_DATA,
  output logic [31:0] CHECK_RS2_DATA,
  output logic [31:0] STALL_CYCLES
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  logic        h_valid;
  logic [31:0] h_pc;
  logic [6:0]  h_opcode;
  logic [4:0]  h_rd;
  logic [4:0]  h_rs1;
  logic [4:0]  h_rs2;
  logic [2:0]  h_funct3;
  logic [6:0]  h_funct7;
  logic [31:0] h_imm;

  logic use_rs1;
  logic use_rs2;
  logic writes_rd;

  // Operand usage is decoded from the held instruction, which the register file is reading for.
  always_comb begin
    use_rs1   = 1'b1;
    use_rs2   = 1'b0;
    writes_rd = (h_rd != 5'd0);
    case (h_opcode)
      OP_LUI, OP_AUIPC, OP_JAL: use_rs1 = 1'b0;
      OP_OP:                    use_rs2 = 1'b1;
      OP_STORE, OP_BRANCH: begin
        use_rs2   = 1'b1;
        writes_rd = 1'b0;
      end
      default: ;
    endcase
  end

  assign STALL        = h_valid & ((use_rs1 & ~REG_A_RVALID) | (use_rs2 & ~REG_B_RVALID));
  assign FWD_REG_ADDR = (h_valid & ~STALL & writes_rd) ? h_rd : 5'd0;

  always_ff @(posedge CLK) begin
    if (RST) begin
      h_valid        <= 1'b0;
      h_pc           <= 32'd0;
      h_opcode       <= 7'd0;
      h_rd           <= 5'd0;
      h_rs1          <= 5'd0;
      h_rs2          <= 5'd0;
      h_funct3       <= 3'd0;
      h_funct7       <= 7'd0;
      h_imm          <= 32'd0;
      CHECK_VALID    <= 1'b0;
      CHECK_PC       <= 32'd0;
      CHECK_OPCODE   <= 7'd0;
      CHECK_RD       <= 5'd0;
      CHECK_RS1      <= 5'd0;
      CHECK_RS2      <= 5'd0;
      CHECK_FUNCT3   <= 3'd0;
      CHECK_FUNCT7   <= 7'd0;
      CHECK_IMM      <= 32'd0;
      CHECK_RS1_DATA <= 32'd0;
      CHECK_RS2_DATA <= 32'd0;
      STALL_CYCLES   <= 32'd0;
    end else begin
      // The stall counter runs even through flush and memory-wait edges.
      if (STALL && STALL_CYCLES != 32'hFFFF_FFFF)
        STALL_CYCLES <= STALL_CYCLES + 32'd1;

      if (FLUSH) begin
        h_valid     <= 1'b0;
        CHECK_VALID <= 1'b0;
      end else if (MEM_WAIT) begin
        h_valid <= h_valid;
      end else if (STALL) begin
        CHECK_VALID <= 1'b0;
      end else begin
        CHECK_VALID    <= h_valid;
        CHECK_PC       <= h_pc;
        CHECK_OPCODE   <= h_opcode;
        CHECK_RD       <= h_rd;
        CHECK_RS1      <= h_rs1;
        CHECK_RS2      <= h_rs2;
        CHECK_FUNCT3   <= h_funct3;
        CHECK_FUNCT7   <= h_funct7;
        CHECK_IMM      <= h_imm;
        CHECK_RS1_DATA <= use_rs1 ? REG_A_RDATA : 32'd0;
        CHECK_RS2_DATA <= use_rs2 ? REG_B_RDATA : 32'd0;
        h_valid        <= DECODE_VALID;
        h_pc           <= DECODE_PC;
        h_opcode       <= DECODE_OPCODE;
        h_rd           <= DECODE_RD;
        h_rs1          <= DECODE_RS1;
        h_rs2          <= DECODE_RS2;
        h_funct3       <= DECODE_FUNCT3;
        h_funct7       <= DECODE_FUNCT7;
        h_imm          <= DECODE_IMM;
      end
    end
  end

endmodule

// File: tb/tb_check_std_rv32i.sv
// Bench for check_std_rv32i: directed pipeline scenarios with literal expectations, plus a
// per-cycle comparison against an instruction-level model of the issue stage.
module tb_check_std_rv32i;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
  } instr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  logic mem_wait = 1'b0;
  instr_t dec = '0;
  logic a_valid = 1'b0, b_valid = 1'b0;
  logic [31:0] a_data = 32'd0, b_data = 32'd0;

  logic        stall;
  logic [4:0]  fwd;
  logic        c_valid;
  logic [31:0] c_pc, c_imm, c_rs1_data, c_rs2_data, stall_cycles;
  logic [6:0]  c_opcode, c_funct7;
  logic [4:0]  c_rd, c_rs1, c_rs2;
  logic [2:0]  c_funct3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  check_std_rv32i dut (
    .CLK(clk), .RST(rst), .FLUSH(flush), .MEM_WAIT(mem_wait),
    .DECODE_VALID(dec.valid), .DECODE_PC(dec.pc), .DECODE_OPCODE(dec.opcode),
    .DECODE_RD(dec.rd), .DECODE_RS1(dec.rs1), .DECODE_RS2(dec.rs2),
    .DECODE_FUNCT3(dec.funct3), .DECODE_FUNCT7(dec.funct7), .DECODE_IMM(dec.imm),
    .REG_A_RVALID(a_valid), .REG_A_RDATA(a_data),
    .REG_B_RVALID(b_valid), .REG_B_RDATA(b_data),
    .STALL(stall), .FWD_REG_ADDR(fwd),
    .CHECK_VALID(c_valid), .CHECK_PC(c_pc), .CHECK_OPCODE(c_opcode), .CHECK_RD(c_rd),
    .CHECK_RS1(c_rs1), .CHECK_RS2(c_rs2), .CHECK_FUNCT3(c_funct3), .CHECK_FUNCT7(c_funct7),
    .CHECK_IMM(c_imm), .CHECK_RS1_DATA(c_rs1_data), .CHECK_RS2_DATA(c_rs2_data),
    .STALL_CYCLES(stall_cycles)
  );

  // Instruction-level model: one waiting instruction, one issued instruction with operands.
  instr_t      m_wait;
  instr_t      m_issued;
  logic [31:0] m_op_a, m_op_b;
  longint      m_stalls = 0;
  bit          started = 1'b0;

  function automatic bit reads_a(input logic [6:0] op);
    return !(op == 7'b0110111 || op == 7'b0010111 || op == 7'b1101111);
  endfunction

  function automatic bit reads_b(input logic [6:0] op);
    return op == 7'b0110011 || op == 7'b0100011 || op == 7'b1100011;
  endfunction

  function automatic bit has_dest(input instr_t i);
    return i.rd != 5'd0 && i.opcode != 7'b0100011 && i.opcode != 7'b1100011;
  endfunction

  function automatic bit model_stall();
    if (!m_wait.valid) return 1'b0;
    return (reads_a(m_wait.opcode) && !a_valid) || (reads_b(m_wait.opcode) && !b_valid);
  endfunction

  function automatic logic [4:0] model_fwd();
    if (m_wait.valid && !model_stall() && has_dest(m_wait)) return m_wait.rd;
    return 5'd0;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_wait = '0; m_issued = '0; m_op_a = 0; m_op_b = 0; m_stalls = 0;
      started = 1'b1;
    end else begin
      bit st;
      st = model_stall();
      if (st) m_stalls = (m_stalls >= 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_stalls + 1;
      if (flush) begin
        m_wait.valid = 1'b0;
        m_issued.valid = 1'b0;
      end else if (!mem_wait) begin
        if (st) m_issued.valid = 1'b0;
        else begin
          m_issued = m_wait;
          m_op_a = reads_a(m_wait.opcode) ? a_data : 32'd0;
          m_op_b = reads_b(m_wait.opcode) ? b_data : 32'd0;
          m_wait = dec;
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (started && !rst) begin
      checkOutput("model_stall", {31'd0, stall}, {31'd0, model_stall()});
      checkOutput("model_fwd", {27'd0, fwd}, {27'd0, model_fwd()});
      checkOutput("model_valid", {31'd0, c_valid}, {31'd0, m_issued.valid});
      checkOutput("model_stall_cycles", stall_cycles, m_stalls[31:0]);
      if (m_issued.valid) begin
        checkOutput("model_pc", c_pc, m_issued.pc);
        checkOutput("model_opcode", {25'd0, c_opcode}, {25'd0, m_issued.opcode});
        checkOutput("model_rd", {27'd0, c_rd}, {27'd0, m_issued.rd});
        checkOutput("model_rs1", {27'd0, c_rs1}, {27'd0, m_issued.rs1});
        checkOutput("model_rs2", {27'd0, c_rs2}, {27'd0, m_issued.rs2});
        checkOutput("model_funct3", {29'd0, c_funct3}, {29'd0, m_issued.funct3});
        checkOutput("model_funct7", {25'd0, c_funct7}, {25'd0, m_issued.funct7});
        checkOutput("model_imm", c_imm, m_issued.imm);
        checkOutput("model_rs1_data", c_rs1_data, m_op_a);
        checkOutput("model_rs2_data", c_rs2_data, m_op_b);
      end
    end
  end

  function automatic instr_t mk(input logic v, input logic [31:0] pc, input logic [6:0] op,
                                input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm);
    instr_t i;
    i = '{valid: v, pc: pc, opcode: op, rd: rd, rs1: rs1, rs2: rs2,
          funct3: f3, funct7: f7, imm: imm};
    return i;
  endfunction

  task automatic applyStimulus(input instr_t i, input logic av, input logic [31:0] ad,
                               input logic bv, input logic [31:0] bd);
    dec = i; a_valid = av; a_data = ad; b_valid = bv; b_data = bd;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  logic [6:0] ops [9] = '{7'b0010011, 7'b0110011, 7'b0110111, 7'b0010111, 7'b1101111,
                          7'b0100011, 7'b1100011, 7'b0000011, 7'b1100111};

  initial begin
    instr_t nop;
    nop = '0;

    // Reset with random inputs.
    applyStimulus(mk(1'b1, $urandom, ops[$urandom_range(0, 8)], 5'($urandom), 5'($urandom),
                     5'($urandom), 3'($urandom), 7'($urandom), $urandom),
                  1'($urandom), $urandom, 1'($urandom), $urandom);
    tick(); tick(); settle();
    checkOutput("reset_valid", {31'd0, c_valid}, 32'd0);
    checkOutput("reset_pc", c_pc, 32'd0);
    checkOutput("reset_imm", c_imm, 32'd0);
    checkOutput("reset_rs1_data", c_rs1_data, 32'd0);
    checkOutput("reset_stall", {31'd0, stall}, 32'd0);
    checkOutput("reset_fwd", {27'd0, fwd}, 32'd0);
    checkOutput("reset_stall_cycles", stall_cycles, 32'd0);
    rst = 1'b0;

    // Independent stream: ADDI x1,x0,5 then ADD x3,x2,x2.
    applyStimulus(mk(1, 32'h100, 7'b0010011, 1, 0, 5, 0, 0, 5), 1, 0, 1, 0);
    tick();
    applyStimulus(mk(1, 32'h104, 7'b0110011, 3, 2, 2, 0, 0, 0), 1, 0, 1, 0);
    settle();
    checkOutput("addi_fwd", {27'd0, fwd}, 32'd1);
    checkOutput("addi_nostall", {31'd0, stall}, 32'd0);
    tick();
    applyStimulus(nop, 1, 7, 1, 7);
    settle();
    checkOutput("addi_valid", {31'd0, c_valid}, 32'd1);
    checkOutput("addi_rd", {27'd0, c_rd}, 32'd1);
    checkOutput("addi_imm", c_imm, 32'd5);
    checkOutput("add_fwd", {27'd0, fwd}, 32'd3);
    tick();

    // Hazard: ADD x4,x1,x5 with A invalid for two cycles.
    applyStimulus(mk(1, 32'h108, 7'b0110011, 4, 1, 5, 0, 0, 0), 1, 0, 1, 0);
    settle();
    checkOutput("add_valid", {31'd0, c_valid}, 32'd1);
    checkOutput("add_pc", c_pc, 32'h104);
    checkOutput("add_rs1_data", c_rs1_data, 32'd7);
    checkOutput("add_rs2_data", c_rs2_data, 32'd7);
    tick();
    applyStimulus(nop, 0, 32'h10, 1, 32'h22);
    settle();
    checkOutput("haz_stall0", {31'd0, stall}, 32'd1);
    checkOutput("haz_fwd0", {27'd0, fwd}, 32'd0);
    tick(); settle();
    checkOutput("haz_stall1", {31'd0, stall}, 32'd1);
    checkOutput("haz_bubble1", {31'd0, c_valid}, 32'd0);
    checkOutput("haz_cycles1", stall_cycles, 32'd1);
    tick();
    a_valid = 1'b1;
    settle();
    checkOutput("haz_release", {31'd0, stall}, 32'd0);
    checkOutput("haz_fwd", {27'd0, fwd}, 32'd4);
    checkOutput("haz_bubble2", {31'd0, c_valid}, 32'd0);
    tick();

    // Unused operands: LUI x6,0x12345 with both read ports invalid.
    applyStimulus(mk(1, 32'h10C, 7'b0110111, 6, 8, 3, 5, 0, 32'h1234_5000), 0, 32'hDEAD, 0, 32'hBEEF);
    settle();
    checkOutput("haz_issue", {31'd0, c_valid}, 32'd1);
    checkOutput("haz_rs1_data", c_rs1_data, 32'h10);
    checkOutput("haz_rs2_data", c_rs2_data, 32'h22);
    checkOutput("haz_cycles", stall_cycles, 32'd2);
    tick();
    dec = nop;
    settle();
    checkOutput("lui_nostall", {31'd0, stall}, 32'd0);
    checkOutput("lui_fwd", {27'd0, fwd}, 32'd6);
    tick();

    // Store: SW x7,4(x8) waits for B.
    dec = mk(1, 32'h110, 7'b0100011, 4, 8, 7, 3'b010, 0, 4);
    settle();
    checkOutput("lui_imm", c_imm, 32'h1234_5000);
    checkOutput("lui_rs1_data", c_rs1_data, 32'd0);
    checkOutput("lui_rs2_data", c_rs2_data, 32'd0);
    tick();
    applyStimulus(nop, 1, 32'h1000, 0, 32'h77);
    settle();
    checkOutput("sw_stall", {31'd0, stall}, 32'd1);
    checkOutput("sw_fwd_stalled", {27'd0, fwd}, 32'd0);
    tick();
    b_valid = 1'b1;
    settle();
    checkOutput("sw_release", {31'd0, stall}, 32'd0);
    checkOutput("sw_fwd", {27'd0, fwd}, 32'd0);
    tick();

    // MEM_WAIT during a stall, then FLUSH mid-stall.
    applyStimulus(mk(1, 32'h120, 7'b0010011, 10, 1, 0, 0, 0, 0), 1, 0, 1, 0);
    settle();
    checkOutput("sw_rs1_data", c_rs1_data, 32'h1000);
    checkOutput("sw_rs2_data", c_rs2_data, 32'h77);
    checkOutput("sw_cycles", stall_cycles, 32'd3);
    tick();
    dec = mk(1, 32'h124, 7'b0110011, 9, 1, 2, 0, 0, 0);
    settle();
    tick();
    dec = nop; a_valid = 1'b0; mem_wait = 1'b1;
    settle();
    checkOutput("mw_stall", {31'd0, stall}, 32'd1);
    checkOutput("mw_valid_before", {31'd0, c_valid}, 32'd1);
    tick();
    mem_wait = 1'b0; flush = 1'b1;
    settle();
    checkOutput("mw_valid_held", {31'd0, c_valid}, 32'd1);
    checkOutput("mw_rd_held", {27'd0, c_rd}, 32'd10);
    checkOutput("mw_cycles", stall_cycles, 32'd4);
    tick();
    flush = 1'b0;
    settle();
    checkOutput("flush_stall", {31'd0, stall}, 32'd0);
    checkOutput("flush_valid", {31'd0, c_valid}, 32'd0);
    checkOutput("flush_cycles", stall_cycles, 32'd5);
    tick(); settle();
    checkOutput("post_flush_cycles", stall_cycles, 32'd5);

    // Mixed traffic checked by the model; decode holds while stalled or frozen.
    for (int n = 0; n < 300; n++) begin
      tick();
      a_valid  = ($urandom_range(0, 9) < 7);
      b_valid  = ($urandom_range(0, 9) < 7);
      a_data   = $urandom;
      b_data   = $urandom;
      mem_wait = ($urandom_range(0, 7) == 0);
      flush    = ($urandom_range(0, 19) == 0);
      if (!(model_stall() || mem_wait))
        dec = mk(1'($urandom_range(0, 3) != 0), $urandom, ops[$urandom_range(0, 8)],
                 5'($urandom_range(0, 7)), 5'($urandom), 5'($urandom), 3'($urandom),
                 7'($urandom), $urandom);
      settle();
    end
    flush = 1'b0; mem_wait = 1'b0; dec = nop;
    tick(); tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
